// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset cpu: ISA encodings,
// FSM states, ALU operation codes, instruction classes and a decode helper.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MEM_DEPTH = 4096;
    localparam int unsigned MEM_AW    = 12;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned REG_COUNT = 32;

    localparam logic [XLEN-1:0] RESET_SP = 32'h3FFC;
    localparam logic [REG_AW-1:0] REG_SP = 5'd29;
    localparam logic [REG_AW-1:0] REG_RA = 5'd31;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_XOR,
        ALU_PASS
    } alu_op_t;

    typedef enum logic [3:0] {
        IC_ADD,
        IC_SUB,
        IC_SLT,
        IC_JR,
        IC_ADDI,
        IC_XORI,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_BNE,
        IC_J,
        IC_JAL,
        IC_NOP
    } ins_class_t;

    // R-format view of an instruction word
    typedef struct packed {
        logic [5:0]        op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
    } rfmt_t;

    // Map an instruction word onto its class; unknown encodings become NOP.
    function automatic ins_class_t decode_class(input logic [XLEN-1:0] ins);
        rfmt_t f;
        ins_class_t c;
        f = ins;
        c = IC_NOP;
        case (f.op)
            OP_RTYPE: begin
                case (f.funct)
                    FN_ADD:  c = IC_ADD;
                    FN_SUB:  c = IC_SUB;
                    FN_SLT:  c = IC_SLT;
                    FN_JR:   c = IC_JR;
                    default: c = IC_NOP;
                endcase
            end
            OP_J:    c = IC_J;
            OP_JAL:  c = IC_JAL;
            OP_BEQ:  c = IC_BEQ;
            OP_BNE:  c = IC_BNE;
            OP_ADDI: c = IC_ADDI;
            OP_XORI: c = IC_XORI;
            OP_LW:   c = IC_LW;
            OP_SW:   c = IC_SW;
            default: c = IC_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add, subtract, signed set-less-than, xor, pass-through.
// Ports: op (operation), a/b (operands), result_c, zero_c (result == 0).
module alu
    import cpu_pkg::*;
(
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result_c,
    output logic             zero_c
);

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_SLT:  result_c = {31'd0, ($signed(a) < $signed(b))};
            ALU_XOR:  result_c = a ^ b;
            ALU_PASS: result_c = b;
            default:  result_c = '0;
        endcase
    end

    assign zero_c = (result_c == '0);

endmodule

// File: rtl/cpu_memory.sv
// Unified instruction/data RAM, 4096 words, combinational read and
// synchronous write. Contents are never cleared. Addresses are word indices;
// the cpu drops byte-offset and high address bits so addresses alias.
// Ports: clk, raddr -> rdata_c, we/waddr/wdata.
module memory
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic [MEM_AW-1:0] raddr,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata_c
);

    logic [XLEN-1:0] mem [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file, two asynchronous read ports and one synchronous write
// port. $0 reads as zero and ignores writes; reset loads $sp with RESET_SP.
// Ports: clk, reset, raddr1/raddr2 -> rdata1_c/rdata2_c, we/waddr/wdata.
module regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata1_c,
    output logic [XLEN-1:0]   rdata2_c
);

    logic [XLEN-1:0] regs [0:REG_COUNT-1];

    // Reset all registers; write port ignores $0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= (i == int'(REG_SP)) ? RESET_SP : '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1_c = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2_c = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu.sv
// Multicycle 32-bit MIPS-subset processor (top). Runs the program held in
// memory.mem from address 0 after reset; no data ports.
// Ports: clk (rising-edge clock), reset (synchronous, active-high).
module cpu
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] PC_A;
    logic [XLEN-1:0] INS_A;
    logic [XLEN-1:0] a_q, b_q, imm_q, aluout_q, mdr_q;

    ins_class_t      cls;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [XLEN-1:0] rs_val_c, rt_val_c, mem_rdata_c;
    logic [XLEN-1:0] imm_ext_c, alu_b_c, alu_res_c;
    logic [XLEN-1:0] branch_target_c, jump_target_c, pc_next_c;
    logic            alu_zero_c;
    alu_op_t         alu_op_c;

    logic              pc_we_c, ir_we_c, ab_we_c, alu_we_c, mdr_we_c;
    logic              rf_we_c, mem_we_c, mem_sel_data_c;
    logic [REG_AW-1:0] rf_waddr_c;
    logic [XLEN-1:0]   rf_wdata_c;

    // Instruction field decode
    always_comb begin
        cls = decode_class(INS_A);
        rs  = INS_A[25:21];
        rt  = INS_A[20:16];
        rd  = INS_A[15:11];
        imm_ext_c = (cls == IC_XORI) ? {16'd0, INS_A[15:0]}
                                     : {{16{INS_A[15]}}, INS_A[15:0]};
    end

    // ALU operation and second-operand select
    always_comb begin
        alu_op_c = ALU_ADD;
        alu_b_c  = imm_q;
        case (cls)
            IC_SUB:         begin alu_op_c = ALU_SUB; alu_b_c = b_q; end
            IC_SLT:         begin alu_op_c = ALU_SLT; alu_b_c = b_q; end
            IC_ADD:         begin alu_op_c = ALU_ADD; alu_b_c = b_q; end
            IC_BEQ, IC_BNE: begin alu_op_c = ALU_SUB; alu_b_c = b_q; end
            IC_XORI:        alu_op_c = ALU_XOR;
            default:        alu_op_c = ALU_ADD;
        endcase
    end

    // PC_A already holds PC+4 once the instruction has been fetched
    assign branch_target_c = PC_A + {imm_q[29:0], 2'b00};
    assign jump_target_c   = {PC_A[31:28], INS_A[25:0], 2'b00};

    regfile rf (
        .clk      (clk),
        .reset    (reset),
        .raddr1   (rs),
        .raddr2   (rt),
        .we       (rf_we_c),
        .waddr    (rf_waddr_c),
        .wdata    (rf_wdata_c),
        .rdata1_c (rs_val_c),
        .rdata2_c (rt_val_c)
    );

    alu alu_i (
        .op       (alu_op_c),
        .a        (a_q),
        .b        (alu_b_c),
        .result_c (alu_res_c),
        .zero_c   (alu_zero_c)
    );

    memory memory (
        .clk     (clk),
        .raddr   (mem_sel_data_c ? aluout_q[13:2] : PC_A[13:2]),
        .we      (mem_we_c),
        .waddr   (aluout_q[13:2]),
        .wdata   (b_q),
        .rdata_c (mem_rdata_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d        = state_q;
        pc_we_c        = 1'b0;
        pc_next_c      = PC_A;
        ir_we_c        = 1'b0;
        ab_we_c        = 1'b0;
        alu_we_c       = 1'b0;
        mdr_we_c       = 1'b0;
        rf_we_c        = 1'b0;
        rf_waddr_c     = rt;
        rf_wdata_c     = aluout_q;
        mem_we_c       = 1'b0;
        mem_sel_data_c = 1'b0;

        case (state_q)
            FETCH: begin
                ir_we_c   = 1'b1;
                pc_we_c   = 1'b1;
                pc_next_c = PC_A + 32'd4;
                state_d   = DECODE;
            end
            DECODE: begin
                ab_we_c = 1'b1;
                case (cls)
                    IC_J: begin
                        pc_we_c   = 1'b1;
                        pc_next_c = jump_target_c;
                        state_d   = FETCH;
                    end
                    IC_JAL: begin
                        pc_we_c    = 1'b1;
                        pc_next_c  = jump_target_c;
                        rf_we_c    = 1'b1;
                        rf_waddr_c = REG_RA;
                        rf_wdata_c = PC_A;
                        state_d    = FETCH;
                    end
                    IC_JR: begin
                        pc_we_c   = 1'b1;
                        pc_next_c = rs_val_c;
                        state_d   = FETCH;
                    end
                    IC_NOP:  state_d = FETCH;
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                alu_we_c = 1'b1;
                case (cls)
                    IC_BEQ, IC_BNE: begin
                        if (alu_zero_c == (cls == IC_BEQ)) begin
                            pc_we_c   = 1'b1;
                            pc_next_c = branch_target_c;
                        end
                        state_d = FETCH;
                    end
                    IC_LW, IC_SW: state_d = MEM;
                    default:      state_d = WB;
                endcase
            end
            MEM: begin
                mem_sel_data_c = 1'b1;
                if (cls == IC_SW) begin
                    mem_we_c = 1'b1;
                    state_d  = FETCH;
                end else begin
                    mdr_we_c = 1'b1;
                    state_d  = WB;
                end
            end
            WB: begin
                rf_we_c = 1'b1;
                case (cls)
                    IC_ADD, IC_SUB, IC_SLT: rf_waddr_c = rd;
                    IC_LW:                  rf_wdata_c = mdr_q;
                    default:                rf_waddr_c = rt;
                endcase
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset cancels any write the current state would commit
        if (reset) begin
            rf_we_c  = 1'b0;
            mem_we_c = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_A     <= '0;
            INS_A    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (pc_we_c)  PC_A     <= pc_next_c;
            if (ir_we_c)  INS_A    <= mem_rdata_c;
            if (ab_we_c) begin
                a_q   <= rs_val_c;
                b_q   <= rt_val_c;
                imm_q <= imm_ext_c;
            end
            if (alu_we_c) aluout_q <= alu_res_c;
            if (mdr_we_c) mdr_q    <= mem_rdata_c;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: loads small programs into memory, pushes the
// expected architectural state to a scoreboard, runs a fixed number of cycles
// and compares registers, memory words and PC against the queued values.
module tb_cpu;

    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;
    localparam int K_IR  = 3;

    localparam int T0 = 8, T1 = 9, T2 = 10, T3 = 11, T4 = 12, T5 = 13;
    localparam int SP = 29, RA = 31;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          q_kind [$];
    int          q_idx  [$];
    logic [31:0] q_val  [$];
    string       q_tag  [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int funct, input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int addr);
        return {6'(op), 26'(addr >> 2)};
    endfunction

    task automatic expect_val(input int kind, input int idx, input logic [31:0] val, input string tag);
        q_kind.push_back(kind);
        q_idx.push_back(idx);
        q_val.push_back(val);
        q_tag.push_back(tag);
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.rf.regs[idx];
            K_MEM:   return dut.memory.mem[idx];
            K_PC:    return dut.PC_A;
            default: return dut.INS_A;
        endcase
    endfunction

    task automatic drain();
        while (q_kind.size() > 0) begin
            int          k, i;
            logic [31:0] v;
            string       t;
            k = q_kind.pop_front();
            i = q_idx.pop_front();
            v = q_val.pop_front();
            t = q_tag.pop_front();
            check_eq(t, observe(k, i), v);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset for one edge, then clear memory and load the program
    task automatic load_prog(input logic [31:0] prog [$]);
        reset = 1'b1;
        cycles(1);
        for (int i = 0; i < 4096; i++) dut.memory.mem[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.memory.mem[i] = prog[i];
    endtask

    initial begin
        logic [31:0] prog [$];

        // Reset behaviour and first-instruction timing
        prog = '{enc_i(8, 0, T0, 5)};
        load_prog(prog);
        cycles(2);
        expect_val(K_PC, 0, 32'h0, "rst_pc");
        expect_val(K_IR, 0, 32'h0, "rst_ir");
        expect_val(K_REG, SP, 32'h3FFC, "rst_sp");
        expect_val(K_REG, T0, 32'h0, "rst_t0");
        drain();
        reset = 1'b0;
        cycles(6);
        expect_val(K_REG, T0, 32'd5, "rst_run_t0");
        expect_val(K_PC, 0, 32'h8, "rst_run_pc");
        drain();

        // Arithmetic
        prog = '{enc_i(8, 0, T0, 7), enc_i(8, 0, T1, -3),
                 enc_r(32'h20, T0, T1, T2), enc_r(32'h22, T1, T0, T3),
                 enc_r(32'h2A, T1, T0, T4), enc_i(32'h0E, T0, T5, 32'hFFFF)};
        load_prog(prog);
        cycles(2);
        reset = 1'b0;
        expect_val(K_REG, T2, 32'd4, "add");
        expect_val(K_REG, T3, 32'hFFFF_FFF6, "sub");
        expect_val(K_REG, T4, 32'd1, "slt");
        expect_val(K_REG, T5, 32'h0000_FFF8, "xori");
        expect_val(K_REG, T1, 32'hFFFF_FFFD, "addi_neg");
        expect_val(K_REG, SP, 32'h3FFC, "sp_kept");
        cycles(30);
        drain();

        // Store, load and write to $0
        prog = '{enc_i(8, 0, T0, 32'h55), enc_i(32'h2B, 0, T0, 32'h2000),
                 enc_i(32'h23, 0, T1, 32'h2000), enc_i(8, 0, 0, 9)};
        load_prog(prog);
        cycles(2);
        reset = 1'b0;
        expect_val(K_MEM, 32'h800, 32'h55, "sw_mem");
        expect_val(K_REG, T1, 32'h55, "lw_t1");
        expect_val(K_REG, 0, 32'h0, "zero_reg");
        cycles(25);
        drain();

        // Branches and counted loop, ending in a jump-to-self at 0x28
        prog = '{enc_i(8, 0, T0, 3), enc_i(8, 0, T1, 3),
                 enc_i(4, T0, T1, 1), enc_i(8, 0, T2, 1),
                 enc_i(5, T0, T1, 1), enc_i(8, 0, T3, 2),
                 enc_i(8, 0, T4, 0), enc_i(8, 0, T5, 4),
                 enc_i(8, T4, T4, 1), enc_i(5, T4, T5, -2),
                 enc_j(2, 32'h28)};
        load_prog(prog);
        cycles(2);
        reset = 1'b0;
        expect_val(K_REG, T2, 32'h0, "beq_taken_skip");
        expect_val(K_REG, T3, 32'd2, "bne_fallthru");
        expect_val(K_REG, T4, 32'd4, "loop_count");
        expect_val(K_PC, 0, 32'h28, "spin_pc0");
        cycles(80);
        drain();
        expect_val(K_PC, 0, 32'h2C, "spin_pc1");
        cycles(1);
        drain();
        expect_val(K_PC, 0, 32'h28, "spin_pc2");
        cycles(1);
        drain();

        // JAL / JR
        prog = '{enc_i(8, 0, T0, 1), 32'd0, 32'd0, 32'd0,
                 enc_j(3, 32'h40), enc_i(8, 0, T1, 7), enc_j(2, 32'h18)};
        for (int i = prog.size(); i < 16; i++) prog.push_back(32'd0);
        prog.push_back(enc_i(8, 0, T2, 9));
        prog.push_back(enc_r(32'h08, RA, 0, 0));
        load_prog(prog);
        cycles(2);
        reset = 1'b0;
        expect_val(K_PC, 0, 32'h14, "jr_return_pc");
        expect_val(K_REG, RA, 32'h14, "jal_ra");
        expect_val(K_REG, T2, 32'd9, "callee_ran");
        cycles(18);
        drain();
        expect_val(K_REG, T1, 32'd7, "after_return");
        cycles(20);
        drain();

        // Reset during the MEM cycle of a store
        prog = '{enc_i(8, 0, T0, 32'h77), enc_i(32'h2B, 0, T0, 32'h100)};
        load_prog(prog);
        dut.memory.mem[32'h40] = 32'hDEAD_BEEF;
        cycles(2);
        reset = 1'b0;
        cycles(7);
        expect_val(K_REG, T0, 32'h77, "pre_rst_t0");
        drain();
        reset = 1'b1;
        expect_val(K_MEM, 32'h40, 32'hDEAD_BEEF, "sw_suppressed");
        expect_val(K_PC, 0, 32'h0, "midrst_pc");
        expect_val(K_REG, T0, 32'h0, "midrst_t0");
        cycles(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu.md
# cpu

Multicycle 32-bit MIPS-subset processor with a unified instruction/data memory, forming the top level of the design. It executes a program preloaded as hex words into its internal memory, starting from address 0 after reset. It has no data ports; verification observes internal state hierarchically through `cpu.memory.mem`, the PC, and the register file.

## Interface

- No parameters; memory depth is fixed at 4096 words (16 KB).
- `clk  input  1  system clock; all state updates on rising edge`
- `reset  input  1  synchronous, active-high; held high = CPU held in reset state`
- One clock; reset is synchronous and active-high.
- Required hierarchical names:
  - `memory`: memory instance.
  - `memory.mem[0:4095]`: 32-bit word array, loadable by `$readmemh` at index 0.
  - `PC_A`: current PC.
  - `INS_A`: instruction register.

## Operation

- ISA subset (MIPS encodings):
  - R-type: ADD, SUB, SLT, JR.
  - I-type: LW, SW, BEQ, BNE, ADDI, XORI.
  - J-type: J, JAL.
- ADD/SUB/ADDI wrap on overflow; no exceptions.
- SLT is a signed compare.
- Immediate extension:
  - ADDI, LW, SW, BEQ, BNE: sign-extend imm16.
  - XORI: zero-extend imm16.
- Branch taken: PC = PC+4 + (sext(imm)<<2).
- J/JAL target: {PC+4[31:28], target26, 2'b00}.
- JAL writes PC+4 to $31.
- JR: PC = rs.
- Any other opcode/funct executes as NOP (PC+4, no writes).
- Register file: 32×32.
  - $0 always reads 0; writes to it are ignored.
  - Two async read ports, one sync write port.
- Memory:
  - Byte address bits [13:2] select the word; bits [1:0] ignored.
  - Address bits [31:14] ignored, so addresses alias.
  - Combinational read, synchronous write.
- Reset values:
  - PC_A = 0, state = FETCH, INS_A = 0.
  - All registers 0 except $sp ($29) = 0x00003FFC.
  - Memory contents are NOT cleared.
- FSM states: FETCH, DECODE, EXEC, MEM, WB.
  - FETCH: INS_A ← mem[PC]; PC ← PC+4 → DECODE.
  - DECODE: latch A=rs, B=rt, sign/zero-extended immediate.
    - J, JAL, JR, and NOP complete here → FETCH.
  - EXEC: ALU result latched.
    - BEQ/BNE update PC if taken → FETCH.
    - R-type/ADDI/XORI → WB.
    - LW/SW → MEM.
  - MEM: SW writes B to mem → FETCH; LW latches read data → WB.
  - WB: write rd (R-type), rt (ADDI/XORI), or rt ← loaded data (LW) → FETCH.

## Timing

- CPI per instruction:
  - J/JAL/JR/NOP: 2.
  - BEQ/BNE: 3.
  - SW: 4.
  - R-type/ADDI/XORI: 4.
  - LW: 5.
- Reset wins over any in-progress instruction:
  - Asserting reset in any state returns to FETCH with PC=0 at the next edge.
  - Pending register/memory writes in that cycle are suppressed.
- First fetch occurs on the first rising edge after reset deasserts.
- A load immediately after a store to the same address returns the stored value (no hazards; multicycle).
- PC wraps modulo 2^32; fetch address aliases per the memory rule.

## Structure

- Shared package `cpu_pkg`:
  - opcode/funct constants.
  - FSM state enum.
  - ALU operation codes.
  - `RESET_SP = 32'h3FFC`.
- Sub-modules:
  - `memory` (unified RAM, instance name `memory`).
  - `regfile`.
  - `alu` (ADD, SUB, SLT, XOR, pass; outputs result and zero flag).
- FSM and datapath registers (PC, IR, A, B, ALUOut, MDR) live in `cpu`.

## Test plan

- Reset: program with `addi $t0,$zero,5` at 0.
  - Hold reset 3 cycles → PC_A=0, $sp=0x3FFC, $t0=0.
  - Release → after 6 cycles $t0=5, PC_A=8.
- Arithmetic: `addi $t0,$0,7; addi $t1,$0,-3; add $t2,$t0,$t1; sub $t3,$t1,$t0; slt $t4,$t1,$t0; xori $t5,$t0,0xFFFF` → $t2=4, $t3=0xFFFFFFF6, $t4=1, $t5=0x0000FFF8.
- Memory: `addi $t0,$0,0x55; sw $t0,0x2000($0); lw $t1,0x2000($0)`.
  - Expect mem[0x800]=0x55 and $t1=0x55.
  - A write to $0 leaves $0=0.
- Branches: BEQ taken with equal regs skips next addi; BNE not-taken falls through.
  - Counter loop of 4 iterations ends with count=4.
- Jumps: `jal f` at 0x10 → $ra=0x14; f executes `jr $ra` → PC returns to 0x14.
  - `j` to self spins with PC constant every 2 cycles.
- Reset mid-operation: assert reset during MEM of an SW → memory unchanged, PC_A=0 next cycle.
